// File: rtl/sdram_device_responder.sv
`default_nettype none
// ============================================================================
// Module   : sdram_device_responder
// Purpose  : Device end of the 16-bit SDR-SDRAM bus: decodes commands, tracks
//            init/bank state, stores masked writes and returns CL-delayed reads.
// Revision : 1.0
// ============================================================================
module sdram_device_responder #(
  parameter int SDRAM_ROW_W   = 13,
  parameter int SDRAM_COL_W   = 9,
  parameter int SDRAM_BANK_W  = 2,
  parameter int MEM_ROW_IDX_W = 2,
  parameter int MEM_COL_IDX_W = 6,
  parameter int TRCD          = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    sdram_cke_i,
  input  logic                    sdram_cs_i,
  input  logic                    sdram_ras_i,
  input  logic                    sdram_cas_i,
  input  logic                    sdram_we_i,
  input  logic [1:0]              sdram_dqm_i,
  input  logic [SDRAM_ROW_W-1:0]  sdram_addr_i,
  input  logic [SDRAM_BANK_W-1:0] sdram_ba_i,
  input  logic [15:0]             sdram_data_in_i,
  output logic [15:0]             sdram_data_out_o,
  output logic                    sdram_data_out_en_o,
  output logic                    init_done_o,
  output logic                    protocol_error_o,
  output logic [2:0]              error_code_o
);

  localparam int NUM_BANKS = 1 << SDRAM_BANK_W;
  localparam int IDX_W     = SDRAM_BANK_W + MEM_ROW_IDX_W + MEM_COL_IDX_W;
  localparam int MEM_DEPTH = 1 << IDX_W;
  localparam int TRCD_W    = (TRCD < 2) ? 1 : $clog2(TRCD + 1);
  localparam logic [TRCD_W-1:0] TRCD_MAX = TRCD_W'(TRCD);
  localparam logic [TRCD_W-1:0] TRCD_ONE = TRCD_W'(1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_TERM = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  typedef enum logic [2:0] {
    INIT_PRE  = 3'd0,
    INIT_REF0 = 3'd1,
    INIT_REF1 = 3'd2,
    INIT_MODE = 3'd3,
    READY     = 3'd4
  } init_state_e;

  init_state_e init_q, init_d;
  logic [1:0] bl_mask_q, bl_mask_d;
  logic       cl3_q, cl3_d;
  logic [NUM_BANKS-1:0]     bank_open_q, bank_open_d;
  logic [MEM_ROW_IDX_W-1:0] bank_row_q [NUM_BANKS];
  logic [MEM_ROW_IDX_W-1:0] bank_row_d [NUM_BANKS];
  logic [TRCD_W-1:0]        trcd_cnt_q [NUM_BANKS];
  logic [TRCD_W-1:0]        trcd_cnt_d [NUM_BANKS];

  logic                     bst_act_q, bst_act_d, bst_wr_q, bst_wr_d, bst_ap_q, bst_ap_d;
  logic [1:0]               bst_k_q, bst_k_d, bst_mask_q, bst_mask_d;
  logic [SDRAM_BANK_W-1:0]  bst_ba_q, bst_ba_d;
  logic [MEM_ROW_IDX_W-1:0] bst_row_q, bst_row_d;
  logic [MEM_COL_IDX_W-1:0] bst_col_q, bst_col_d;

  logic       err_q, err_d;
  logic [2:0] err_code_q, err_code_d;
  logic [2:0]       pipe_vld_q, pipe_vld_d;
  logic [2:0][15:0] pipe_dat_q, pipe_dat_d;
  logic [1:0][1:0]  dqm_dly_q, dqm_dly_d;
  logic [MEM_DEPTH-1:0] valid_q, valid_d;
  logic [15:0] mem_q [MEM_DEPTH];

  logic [3:0] cmd;
  logic is_nop, is_act, is_rd, is_wr, is_rw, is_term, is_pre, is_ref, is_lmr;
  logic a10, trcd_ok, new_ok, out_en, unused_addr;
  logic [MEM_COL_IDX_W-1:0] cmd_col;
  logic [7:0] errs;
  logic [2:0] first_code;
  logic       do_mode, mode_bl_ok, mode_cl_ok, mode_cl3;
  logic [1:0] mode_bl_mask;
  logic                     acc_en, acc_wr;
  logic [SDRAM_BANK_W-1:0]  acc_ba;
  logic [MEM_ROW_IDX_W-1:0] acc_row;
  logic [MEM_COL_IDX_W-1:0] acc_col;
  logic [IDX_W-1:0]         acc_idx;
  logic [15:0] rd_word, wr_word;

  // Sequential wrap: only the BL-aligned low bits advance with the beat index.
  function automatic logic [MEM_COL_IDX_W-1:0] beat_col(
    input logic [MEM_COL_IDX_W-1:0] base, input logic [1:0] mask, input logic [1:0] k);
    logic [MEM_COL_IDX_W-1:0] m, s;
    m = {{(MEM_COL_IDX_W-2){1'b0}}, mask};
    s = base + {{(MEM_COL_IDX_W-2){1'b0}}, k};
    return (base & ~m) | (s & m);
  endfunction

  assign cmd = (sdram_cke_i && !sdram_cs_i) ?
               {sdram_cs_i, sdram_ras_i, sdram_cas_i, sdram_we_i} : CMD_NOP;
  assign is_nop  = (cmd == CMD_NOP);
  assign is_act  = (cmd == CMD_ACT);
  assign is_rd   = (cmd == CMD_RD);
  assign is_wr   = (cmd == CMD_WR);
  assign is_rw   = is_rd || is_wr;
  assign is_term = (cmd == CMD_TERM);
  assign is_pre  = (cmd == CMD_PRE);
  assign is_ref  = (cmd == CMD_REF);
  assign is_lmr  = (cmd == CMD_LMR);
  assign a10     = sdram_addr_i[10];
  assign cmd_col = sdram_addr_i[MEM_COL_IDX_W-1:0];
  assign trcd_ok = (trcd_cnt_q[sdram_ba_i] >= TRCD_MAX);
  assign new_ok  = is_rw && bank_open_q[sdram_ba_i] && trcd_ok;
  assign out_en  = cl3_q ? pipe_vld_q[2] : pipe_vld_q[1];
  // Row/column bits above the storage index are accepted but not stored.
  assign unused_addr = ^sdram_addr_i;

  assign acc_idx = {acc_ba, acc_row, acc_col};
  assign rd_word = valid_q[acc_idx] ? mem_q[acc_idx] : 16'h0000;
  assign wr_word = {sdram_dqm_i[1] ? rd_word[15:8] : sdram_data_in_i[15:8],
                    sdram_dqm_i[0] ? rd_word[7:0]  : sdram_data_in_i[7:0]};

  always_comb begin
    mode_bl_ok   = 1'b1;
    mode_bl_mask = bl_mask_q;
    case (sdram_addr_i[2:0])
      3'b000:  mode_bl_mask = 2'b00;
      3'b001:  mode_bl_mask = 2'b01;
      3'b010:  mode_bl_mask = 2'b11;
      default: mode_bl_ok = 1'b0;
    endcase
    mode_cl_ok = 1'b1;
    mode_cl3   = cl3_q;
    case (sdram_addr_i[6:4])
      3'b010:  mode_cl3 = 1'b0;
      3'b011:  mode_cl3 = 1'b1;
      default: mode_cl_ok = 1'b0;
    endcase
  end

  always_comb begin
    init_d      = init_q;
    bl_mask_d   = bl_mask_q;
    cl3_d       = cl3_q;
    bank_open_d = bank_open_q;
    bank_row_d  = bank_row_q;
    trcd_cnt_d  = trcd_cnt_q;
    bst_act_d   = bst_act_q;
    bst_wr_d    = bst_wr_q;
    bst_ap_d    = bst_ap_q;
    bst_k_d     = bst_k_q;
    bst_mask_d  = bst_mask_q;
    bst_ba_d    = bst_ba_q;
    bst_row_d   = bst_row_q;
    bst_col_d   = bst_col_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    errs        = 8'h00;
    first_code  = 3'd0;
    do_mode     = 1'b0;
    acc_en      = 1'b0;
    acc_wr      = 1'b0;
    acc_ba      = bst_ba_q;
    acc_row     = bst_row_q;
    acc_col     = beat_col(bst_col_q, bst_mask_q, bst_k_q);

    for (int b = 0; b < NUM_BANKS; b++) begin
      if (trcd_cnt_q[b] < TRCD_MAX) trcd_cnt_d[b] = trcd_cnt_q[b] + TRCD_ONE;
    end

    case (init_q)
      INIT_PRE: begin
        if (is_pre && a10) init_d = INIT_REF0;
        else if (!is_nop)  errs[1] = 1'b1;
      end
      INIT_REF0: begin
        if (is_ref)       init_d = INIT_REF1;
        else if (!is_nop) errs[1] = 1'b1;
      end
      INIT_REF1: begin
        if (is_ref)       init_d = INIT_MODE;
        else if (!is_nop) errs[1] = 1'b1;
      end
      INIT_MODE: begin
        if (is_lmr) begin
          init_d  = READY;
          do_mode = 1'b1;
        end else if (!is_nop) begin
          errs[1] = 1'b1;
        end
      end
      READY: begin
        // A beat due this cycle still issues unless a valid new access takes the slot.
        if (bst_act_q) begin
          if (!new_ok) begin
            acc_en  = 1'b1;
            acc_wr  = bst_wr_q;
            bst_k_d = bst_k_q + 2'd1;
          end
          if (is_rw || is_term || (bst_k_q == bst_mask_q)) begin
            bst_act_d = 1'b0;
            if (bst_ap_q) bank_open_d[bst_ba_q] = 1'b0;
          end
        end
        if (is_rw) begin
          if (!bank_open_q[sdram_ba_i]) begin
            errs[3] = 1'b1;
          end else if (!trcd_ok) begin
            errs[5] = 1'b1;
          end else begin
            acc_en  = 1'b1;
            acc_wr  = is_wr;
            acc_ba  = sdram_ba_i;
            acc_row = bank_row_q[sdram_ba_i];
            acc_col = cmd_col;
            if (bl_mask_q != 2'b00) begin
              bst_act_d  = 1'b1;
              bst_wr_d   = is_wr;
              bst_ap_d   = a10;
              bst_k_d    = 2'd1;
              bst_mask_d = bl_mask_q;
              bst_ba_d   = sdram_ba_i;
              bst_row_d  = bank_row_q[sdram_ba_i];
              bst_col_d  = cmd_col;
            end else if (a10) begin
              bank_open_d[sdram_ba_i] = 1'b0;
            end
          end
          if (is_wr && out_en) errs[7] = 1'b1;
        end
        if (is_act) begin
          if (bank_open_q[sdram_ba_i]) begin
            errs[2] = 1'b1;
          end else begin
            bank_open_d[sdram_ba_i] = 1'b1;
            bank_row_d[sdram_ba_i]  = sdram_addr_i[MEM_ROW_IDX_W-1:0];
            trcd_cnt_d[sdram_ba_i]  = TRCD_ONE;
          end
        end
        if (is_pre) begin
          if (a10) bank_open_d = '0;
          else     bank_open_d[sdram_ba_i] = 1'b0;
        end
        if (is_ref && (|bank_open_q)) errs[4] = 1'b1;
        if (is_lmr) begin
          if (|bank_open_q) errs[4] = 1'b1;
          else              do_mode = 1'b1;
        end
      end
      default: init_d = INIT_PRE;
    endcase

    if (do_mode) begin
      if (mode_bl_ok) bl_mask_d = mode_bl_mask;
      else            errs[6]   = 1'b1;
      if (mode_cl_ok) cl3_d     = mode_cl3;
      else            errs[6]   = 1'b1;
    end

    for (int i = 7; i >= 1; i--) begin
      if (errs[i]) first_code = 3'(i);
    end
    if (!err_q && (|errs)) begin
      err_d      = 1'b1;
      err_code_d = first_code;
    end
  end

  always_comb begin
    pipe_vld_d = {pipe_vld_q[1:0], acc_en && !acc_wr};
    pipe_dat_d = {pipe_dat_q[1:0], rd_word};
    dqm_dly_d  = {dqm_dly_q[0], sdram_dqm_i};
    valid_d    = valid_q;
    if (acc_en && acc_wr) valid_d[acc_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      init_q      <= INIT_PRE;
      bl_mask_q   <= 2'b00;
      cl3_q       <= 1'b0;
      bank_open_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_row_q[b] <= '0;
        trcd_cnt_q[b] <= '0;
      end
      bst_act_q  <= 1'b0;
      bst_wr_q   <= 1'b0;
      bst_ap_q   <= 1'b0;
      bst_k_q    <= 2'd0;
      bst_mask_q <= 2'b00;
      bst_ba_q   <= '0;
      bst_row_q  <= '0;
      bst_col_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      pipe_vld_q <= 3'b000;
      pipe_dat_q <= '0;
      dqm_dly_q  <= '0;
      valid_q    <= '0;
    end else begin
      init_q      <= init_d;
      bl_mask_q   <= bl_mask_d;
      cl3_q       <= cl3_d;
      bank_open_q <= bank_open_d;
      bank_row_q  <= bank_row_d;
      trcd_cnt_q  <= trcd_cnt_d;
      bst_act_q   <= bst_act_d;
      bst_wr_q    <= bst_wr_d;
      bst_ap_q    <= bst_ap_d;
      bst_k_q     <= bst_k_d;
      bst_mask_q  <= bst_mask_d;
      bst_ba_q    <= bst_ba_d;
      bst_row_q   <= bst_row_d;
      bst_col_q   <= bst_col_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_dat_q  <= pipe_dat_d;
      dqm_dly_q   <= dqm_dly_d;
      valid_q     <= valid_d;
    end
  end

  // Storage needs no reset: the valid bits make unwritten words read as zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i && acc_en && acc_wr) mem_q[acc_idx] <= wr_word;
  end

  assign sdram_data_out_en_o = out_en;
  assign sdram_data_out_o    = out_en ? ((cl3_q ? pipe_dat_q[2] : pipe_dat_q[1]) &
                               {{8{~dqm_dly_q[1][1]}}, {8{~dqm_dly_q[1][0]}}}) : 16'h0000;
  assign init_done_o         = (init_q == READY);
  assign protocol_error_o    = err_q;
  assign error_code_o        = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_device_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_device_responder
// Purpose  : Directed vector table plus hand sequences for the SDRAM responder.
// Revision : 1.0
// ============================================================================
module tb_sdram_device_responder;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] ACT  = 4'b0011;
  localparam logic [3:0] RD   = 4'b0101;
  localparam logic [3:0] WR   = 4'b0100;
  localparam logic [3:0] TERM = 4'b0110;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] REF  = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;

  logic        clk = 1'b0;
  logic        rst, cke, cs, ras, cas, we;
  logic [1:0]  dqm, ba;
  logic [12:0] addr;
  logic [15:0] din, dout;
  logic        en, done, perr;
  logic [2:0]  code;

  always #5 clk = ~clk;

  sdram_device_responder dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .sdram_cke_i         (cke),
    .sdram_cs_i          (cs),
    .sdram_ras_i         (ras),
    .sdram_cas_i         (cas),
    .sdram_we_i          (we),
    .sdram_dqm_i         (dqm),
    .sdram_addr_i        (addr),
    .sdram_ba_i          (ba),
    .sdram_data_in_i     (din),
    .sdram_data_out_o    (dout),
    .sdram_data_out_en_o (en),
    .init_done_o         (done),
    .protocol_error_o    (perr),
    .error_code_o        (code)
  );

  // Inputs for one cycle and the outputs expected in the following cycle.
  typedef struct {
    logic        rst;
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] din;
    logic        en;
    logic [15:0] data;
    logic        done;
    logic        err;
    logic [2:0]  code;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic add(input logic r, input logic k, input logic [3:0] c, input logic [1:0] b,
                     input logic [12:0] a, input logic [1:0] m, input logic [15:0] d,
                     input logic e, input logic [15:0] x, input logic dn, input logic er,
                     input logic [2:0] cd);
    vec_t v;
    v.rst = r; v.cke = k; v.cmd = c; v.ba = b; v.addr = a; v.dqm = m; v.din = d;
    v.en = e; v.data = x; v.done = dn; v.err = er; v.code = cd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic k, input logic [3:0] c, input logic [1:0] b,
                       input logic [12:0] a, input logic [1:0] m, input logic [15:0] d);
    rst = r; cke = k; {cs, ras, cas, we} = c; ba = b; addr = a; dqm = m; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [21:0] act, exp;
    int pulses;
    logic [15:0] data_or;

    rst = 1'b1; cke = 1'b1; {cs, ras, cas, we} = NOP;
    ba = '0; addr = '0; dqm = '0; din = '0;

    // Run 1: init with a gated REFRESH, BL=2 CL=2, wrap read, byte masks, error 5
    add(1,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(1,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,PRE, 0,13'h400,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,0,REF, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,REF, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,REF, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,LMR, 0,13'h021,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,ACT, 1,13'h005,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,WR,  1,13'h010,2'b00,16'hA5A5, 0,16'h0000,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h5A5A, 0,16'h0000,1,0,0);
    add(0,1,RD,  1,13'h011,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 1,16'h5A5A,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 1,16'hA5A5,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,WR,  1,13'h020,2'b00,16'hFFFF, 0,16'h0000,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'hFFFF, 0,16'h0000,1,0,0);
    add(0,1,WR,  1,13'h020,2'b10,16'h1234, 0,16'h0000,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b11,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,RD,  1,13'h020,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 1,16'hFF34,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 1,16'hFFFF,1,0,0);
    add(0,1,RD,  1,13'h020,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b01,16'h0000, 1,16'hFF34,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 1,16'hFF00,1,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,ACT, 2,13'h003,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,RD,  2,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,5);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,5);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,5);
    add(0,1,ACT, 2,13'h003,2'b00,16'h0000, 0,16'h0000,1,1,5);
    // Run 2: a third REFRESH is out of sequence and does not advance init
    add(1,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,PRE, 0,13'h400,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,REF, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,REF, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,REF, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,1,1);
    add(0,1,LMR, 0,13'h032,2'b00,16'h0000, 0,16'h0000,1,1,1);
    // Run 3: closed-bank read, CL=3 BL=4 burst cut by TERMINATE, reset mid-burst
    add(1,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,PRE, 0,13'h400,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,REF, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,REF, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,LMR, 0,13'h032,2'b00,16'h0000, 0,16'h0000,1,0,0);
    add(0,1,RD,  0,13'h004,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,ACT, 0,13'h001,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,WR,  0,13'h004,2'b00,16'h1111, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h2222, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h3333, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h4444, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,RD,  0,13'h005,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,TERM,0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 1,16'h2222,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 1,16'h3333,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,RD,  0,13'h004,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,1,1,3);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 1,16'h1111,1,1,3);
    add(1,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);
    add(0,1,NOP, 0,13'h000,2'b00,16'h0000, 0,16'h0000,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].cke, vecs[i].cmd, vecs[i].ba, vecs[i].addr,
            vecs[i].dqm, vecs[i].din);
      act = {en, dout, done, perr, code};
      exp = {vecs[i].en, vecs[i].data, vecs[i].done, vecs[i].err, vecs[i].code};
      check($sformatf("vec%0d {en,data,done,err,code}", i), 32'(act), 32'(exp));
    end

    // Hand sequence: BL=4 CL=2 auto-precharge read of unwritten words
    drive(1,1,NOP, 0,13'h000,2'b00,16'h0000);
    drive(0,1,PRE, 0,13'h400,2'b00,16'h0000);
    drive(0,1,REF, 0,13'h000,2'b00,16'h0000);
    drive(0,1,REF, 0,13'h000,2'b00,16'h0000);
    check("init_done before LOAD_MODE", 32'(done), 32'd0);
    drive(0,1,LMR, 0,13'h022,2'b00,16'h0000);
    check("init_done after LOAD_MODE", 32'(done), 32'd1);
    drive(0,1,ACT, 3,13'h007,2'b00,16'h0000);
    drive(0,1,NOP, 0,13'h000,2'b00,16'h0000);
    drive(0,1,NOP, 0,13'h000,2'b00,16'h0000);
    drive(0,1,RD,  3,13'h400,2'b00,16'h0000);
    pulses  = 0;
    data_or = 16'h0000;
    for (int c = 0; c < 8; c++) begin
      drive(0,1,NOP, 0,13'h000,2'b00,16'h0000);
      if (en === 1'b1) begin
        pulses++;
        data_or = data_or | dout;
      end
    end
    check("auto-precharge burst beat count", 32'(pulses), 32'd4);
    check("unwritten words read zero", 32'(data_or), 32'd0);
    check("no error before reread", 32'({perr, code}), 32'd0);
    drive(0,1,RD,  3,13'h000,2'b00,16'h0000);
    check("read after auto-precharge {err,code}", 32'({perr, code}), 32'({1'b1, 3'd3}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
